// File: rtl/wishbone_arbiter.sv
// N-primary to 1-secondary Wishbone arbiter with round-robin grant held for a whole cyc.
// Optional watchdog abort of hung transfers is enabled by defining WISHBONE_ARBITER_TIMEOUT_EN.
module wishbone_arbiter #(
    parameter int NUM_PRIMARIES  = 2,
    parameter int DATA_SIZE      = 32,
    parameter int BYTE_SIZE      = 8,
    parameter int ADDR_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic [NUM_PRIMARIES-1:0]                         cyc_p,
    input  logic [NUM_PRIMARIES-1:0]                         stb_p,
    input  logic [NUM_PRIMARIES-1:0]                         we_p,
    input  logic [NUM_PRIMARIES-1:0]                         tgd_p,
    input  logic [NUM_PRIMARIES*(DATA_SIZE/BYTE_SIZE)-1:0]   sel_p,
    input  logic [NUM_PRIMARIES*ADDR_SIZE-1:0]               addr_p,
    input  logic [NUM_PRIMARIES*DATA_SIZE-1:0]               dat_o_p,
    output logic [NUM_PRIMARIES-1:0]                         ack_p,
    output logic [NUM_PRIMARIES*DATA_SIZE-1:0]               dat_i_p,
    output logic                                             cyc_s,
    output logic                                             stb_s,
    output logic                                             we_s,
    output logic                                             tgd_s,
    output logic [DATA_SIZE/BYTE_SIZE-1:0]                   sel_s,
    output logic [ADDR_SIZE-1:0]                             addr_s,
    output logic [DATA_SIZE-1:0]                             dat_i_s,
    input  logic                                             ack_s,
    input  logic [DATA_SIZE-1:0]                             dat_o_s,
    output logic [NUM_PRIMARIES-1:0]                         grant,
    output logic                                             timeout
);

    localparam int SEL_SIZE = DATA_SIZE / BYTE_SIZE;
    localparam int IDX_W    = $clog2(NUM_PRIMARIES);

    if (NUM_PRIMARIES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("wishbone_arbiter: NUM_PRIMARIES must be >= 2 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic {IDLE, GRANTED} state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         last_q, last_d;
    logic [NUM_PRIMARIES-1:0] grant_q, grant_d;

    logic [IDX_W-1:0]         winner;
    logic                     pick_found;
    logic                     active;
    logic                     abort;

    // last_q doubles as the owner index while GRANTED.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_PRIMARIES - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    // Round-robin search starting one past the last served primary.
    always_comb begin
        winner     = last_q;
        pick_found = 1'b0;
        for (int off = 1; off <= NUM_PRIMARIES; off++) begin
            if (!pick_found && cyc_p[(int'(last_q) + off) % NUM_PRIMARIES]) begin
                winner     = IDX_W'((int'(last_q) + off) % NUM_PRIMARIES);
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = GRANTED;
                    last_d  = winner;
                    grant_d = NUM_PRIMARIES'(1) << winner;
                end
            end
            GRANTED: begin
                if (!cyc_p[last_q] || abort) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

`ifdef WISHBONE_ARBITER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_q, wd_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    // Counts stalled strobes of the owner; IDLE clears it so each grant starts fresh.
    always_comb begin
        wd_d = wd_q;
        if (state_q != GRANTED || ack_s) begin
            wd_d = '0;
        end else if (cyc_p[last_q] && stb_p[last_q] && !abort) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    assign abort   = active && (wd_q == WD_W'(TIMEOUT_CYCLES));
    assign timeout = abort;
`else
    assign abort   = 1'b0;
    assign timeout = 1'b0;
`endif

    // Reset masks the passthrough so nothing leaks out during the reset cycle.
    assign active = (state_q == GRANTED) && !reset;
    assign grant  = grant_q;

    always_comb begin
        cyc_s   = 1'b0;
        stb_s   = 1'b0;
        we_s    = 1'b0;
        tgd_s   = 1'b0;
        sel_s   = '0;
        addr_s  = '0;
        dat_i_s = '0;
        if (active) begin
            cyc_s   = cyc_p[last_q] && !abort;
            stb_s   = cyc_p[last_q] && stb_p[last_q] && !abort;
            we_s    = we_p[last_q];
            tgd_s   = tgd_p[last_q];
            sel_s   = sel_p[last_q*SEL_SIZE +: SEL_SIZE];
            addr_s  = addr_p[last_q*ADDR_SIZE +: ADDR_SIZE];
            dat_i_s = dat_o_p[last_q*DATA_SIZE +: DATA_SIZE];
        end
    end

    for (genvar gi = 0; gi < NUM_PRIMARIES; gi++) begin : g_ret
        logic owns;
        assign owns = active && (last_q == IDX_W'(gi));
        assign ack_p[gi] = owns && (ack_s || abort);
        assign dat_i_p[gi*DATA_SIZE +: DATA_SIZE] =
            !owns ? '0 : (abort ? {DATA_SIZE{1'b1}} : dat_o_s);
    end

endmodule
